// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential add/subtract unit.
//   state_t     : controller states (IDLE, RUN, DONE)
//   MODE_ADD/SUB: values of the 'sub' mode bit
//   step_width  : width of the step counter for a given step count (minimum 1)
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int step_width(input int num_steps);
        return (num_steps > 1) ? $clog2(num_steps) : 1;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple add/subtract slice built from per-bit cells.
// Ports:
//   x, y : CHUNK-bit operand slices
//   sub  : 1 = x - y - cin (cin/cout are borrows), 0 = x + y + cin (carries)
//   cin  : chain bit in
//   s    : CHUNK-bit sum/difference
//   cout : chain bit out of the MSB cell
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             sub,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        // Sum/difference bit is the same XOR for both modes; only the chain
        // logic differs. A borrow is produced when x < y + bin for this bit.
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (sub == MODE_SUB)
                      ? ((~x[i] & y[i]) | (~(x[i] ^ y[i]) & c[i]))
                      : ((x[i] & y[i]) | ((x[i] ^ y[i]) & c[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: processes CHUNK bits per clock, LSB chunk
// first, with a start/busy/done handshake.
// Optional feature: define ADDSUB_SEQ_OVF_EN to register signed overflow on
// ovf; when undefined ovf is tied to 0.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous, active-high reset
//   start  : request, accepted only in IDLE or DONE
//   sub    : 1 = a - b, 0 = a + b (latched with operands)
//   a, b   : WIDTH-bit operands
//   busy   : high while computing
//   done   : one-cycle pulse when result/cout/ovf are valid
//   result : final sum/difference, held until the next completion
//   cout   : carry out (add) or borrow out (sub)
//   ovf    : signed overflow
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NUM_STEPS = WIDTH / CHUNK;
    localparam int STEP_W    = step_width(NUM_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    state_t             state;
    logic [STEP_W-1:0]  step;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sub_q;
    logic               chain;
    logic [WIDTH-1:0]   part;

    int                 idx;
    logic [CHUNK-1:0]   x_chunk;
    logic [CHUNK-1:0]   y_chunk;
    logic [CHUNK-1:0]   s_chunk;
    logic               c_chunk;
    logic [WIDTH-1:0]   full_res;
    logic               last;

    // Select the operand chunk for the current step; full_res is the partial
    // result with the chunk being computed now merged in, so the final value
    // can be registered on the same edge that completes the last step.
    always_comb begin
        idx      = int'(step) * CHUNK;
        x_chunk  = a_q[idx +: CHUNK];
        y_chunk  = b_q[idx +: CHUNK];
        full_res = part;
        full_res[idx +: CHUNK] = s_chunk;
        last     = (state == RUN) && (step == LAST_STEP);
    end

    addsub_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x   (x_chunk),
        .y   (y_chunk),
        .sub (sub_q),
        .cin (chain),
        .s   (s_chunk),
        .cout(c_chunk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            step   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            chain  <= 1'b0;
            part   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= sub;
                        chain <= 1'b0;
                        part  <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    part[idx +: CHUNK] <= s_chunk;
                    chain              <= c_chunk;
                    if (last) begin
                        result <= full_res;
                        cout   <= c_chunk;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDSUB_SEQ_OVF_EN
    logic ovf_next;

    // Signed overflow from operand and result sign bits only.
    always_comb begin
        if (sub_q == MODE_SUB)
            ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (full_res[WIDTH-1] != a_q[WIDTH-1]);
        else
            ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full_res[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (last)
            ovf <= ovf_next;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
